// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and legal parameter limits for the UART receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int c_DATA_BITS_MIN = 5;
    localparam int c_DATA_BITS_MAX = 8;
    localparam int c_OVS_MIN       = 8;
    localparam int c_OVS_MAX       = 32;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module : uart_baud_tick
// Brief  : Oversample tick generator, one pulse every max(div,1) clk cycles.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;

    // A divisor of zero behaves exactly like a divisor of one.
    assign w_last = (div == '0) ? '0 : div - DIV_W'(1);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else if (r_cnt == w_last) begin
            r_cnt <= '0;
            tick  <= 1'b1;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module : uart_rx_cfg
// Brief  : Runtime-configurable oversampling UART receiver with valid/ready out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16,
    parameter int DIV_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rx,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
    input  logic             i_stop2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [7:0]       o_data,
    output logic             o_frame_err,
    output logic             o_parity_err,
    output logic             o_overrun
);

    localparam int c_CNT_W = $clog2(OVS);
    localparam logic [c_CNT_W-1:0] c_SAMP0     = c_CNT_W'(OVS/2 - 1);
    localparam logic [c_CNT_W-1:0] c_SAMP1     = c_CNT_W'(OVS/2);
    localparam logic [c_CNT_W-1:0] c_SAMP2     = c_CNT_W'(OVS/2 + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_TICK = c_CNT_W'(OVS - 1);
    localparam logic [2:0]         c_LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 r_rx_s1, r_rx_s2;
    uart_state_e          r_state;
    logic [c_CNT_W-1:0]   r_tick_cnt;
    logic [1:0]           r_samp;
    logic [2:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc, r_perr, r_ferr;
    logic [DIV_W-1:0]     r_div;
    logic                 r_par_en, r_par_odd, r_stop2;

    logic w_tick, w_restart, w_maj, w_mid, w_end, w_ferr_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    assign w_restart  = (r_state == ST_IDLE) && !r_rx_s2;
    assign w_maj      = maj3(r_samp[0], r_samp[1], r_rx_s2);
    assign w_mid      = w_tick && (r_tick_cnt == c_SAMP2);
    assign w_end      = w_tick && (r_tick_cnt == c_LAST_TICK);
    assign w_ferr_now = r_ferr | ~w_maj;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .div     (r_div),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tick_cnt   <= '0;
            r_samp       <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_div        <= '0;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_stop2      <= 1'b0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (o_valid && i_ready)
                o_valid <= 1'b0;

            if (r_state != ST_IDLE && w_tick) begin
                r_tick_cnt <= (r_tick_cnt == c_LAST_TICK) ? '0 : r_tick_cnt + c_CNT_W'(1);
                if (r_tick_cnt == c_SAMP0) r_samp[0] <= r_rx_s2;
                if (r_tick_cnt == c_SAMP1) r_samp[1] <= r_rx_s2;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s2) begin
                        r_state    <= ST_START;
                        r_tick_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_par_acc  <= 1'b0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_div      <= i_div;
                        r_par_en   <= i_parity_en;
                        r_par_odd  <= i_parity_odd;
                        r_stop2    <= i_stop2;
                    end
                end
                ST_START: begin
                    if (w_mid && w_maj)
                        r_state <= ST_IDLE;
                    else if (w_end)
                        r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_mid) begin
                        r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_par_acc <= r_par_acc ^ w_maj;
                    end
                    if (w_end) begin
                        if (r_bit_idx == c_LAST_BIT)
                            r_state <= r_par_en ? ST_PARITY : ST_STOP;
                        else
                            r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                ST_PARITY: begin
                    if (w_mid)
                        r_perr <= r_par_acc ^ w_maj ^ r_par_odd;
                    if (w_end)
                        r_state <= ST_STOP;
                end
                ST_STOP: begin
                    // Finishing at mid-stop leaves half a bit to catch the next start edge.
                    if (w_mid) begin
                        if (r_stop_idx == r_stop2) begin
                            r_state <= ST_IDLE;
                            if (!o_valid || i_ready) begin
                                o_valid      <= 1'b1;
                                o_data       <= 8'(r_shift);
                                o_frame_err  <= w_ferr_now;
                                o_parity_err <= r_perr;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            r_ferr <= w_ferr_now;
                        end
                    end
                    if (w_end && (r_stop_idx != r_stop2))
                        r_stop_idx <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ============================================================================
// Module : tb_uart_rx_cfg
// Brief  : Directed self-checking bench for uart_rx_cfg (8-bit and 7-bit builds).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int OVS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx8 = 1'b1;
    logic        rx7 = 1'b1;
    logic [15:0] div = 16'd27;
    logic        par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0, ready = 1'b1;

    logic       v8, fe8_o, pe8_o, ovr8_o, v7, fe7_o, pe7_o, ovr7_o;
    logic [7:0] d8_o, d7_o;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_BITS(8), .OVS(OVS), .DIV_W(16)) dut8 (
        .clk(clk), .rst(rst), .i_rx(rx8), .i_div(div), .i_parity_en(par_en),
        .i_parity_odd(par_odd), .i_stop2(stop2), .o_valid(v8), .i_ready(ready),
        .o_data(d8_o), .o_frame_err(fe8_o), .o_parity_err(pe8_o), .o_overrun(ovr8_o)
    );

    uart_rx_cfg #(.DATA_BITS(7), .OVS(OVS), .DIV_W(16)) dut7 (
        .clk(clk), .rst(rst), .i_rx(rx7), .i_div(div), .i_parity_en(par_en),
        .i_parity_odd(par_odd), .i_stop2(stop2), .o_valid(v7), .i_ready(ready),
        .o_data(d7_o), .o_frame_err(fe7_o), .o_parity_err(pe7_o), .o_overrun(ovr7_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame monitor: counts each newly presented frame and each overrun pulse.
    int         frm8 = 0, ov8 = 0, frm7 = 0, ov7 = 0;
    logic [7:0] cap_d8 = '0, cap_d7 = '0;
    logic       cap_fe8 = 0, cap_pe8 = 0, cap_fe7 = 0, cap_pe7 = 0;
    logic       pv8 = 0, phs8 = 0, pv7 = 0, phs7 = 0;

    always @(negedge clk) begin
        if (v8 && (!pv8 || phs8)) begin
            frm8++; cap_d8 = d8_o; cap_fe8 = fe8_o; cap_pe8 = pe8_o;
        end
        if (ovr8_o) ov8++;
        pv8 = v8; phs8 = v8 && ready;
        if (v7 && (!pv7 || phs7)) begin
            frm7++; cap_d7 = d7_o; cap_fe7 = fe7_o; cap_pe7 = pe7_o;
        end
        if (ovr7_o) ov7++;
        pv7 = v7; phs7 = v7 && ready;
    end

    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) rx8 = v; else rx7 = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input int nbits,
                              input bit pen, input bit pbit, input bit s1, input bit s2,
                              input int nstop, input int bitc);
        drive(sel, 1'b0, bitc);
        for (int i = 0; i < nbits; i++) drive(sel, d[i], bitc);
        if (pen) drive(sel, pbit, bitc);
        drive(sel, s1, bitc);
        if (nstop == 2) drive(sel, s2, bitc);
        drive(sel, 1'b1, 0);
    endtask

    function automatic int bit_cycles(input logic [15:0] dv);
        return OVS * ((dv == 16'd0) ? 1 : int'(dv));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, bo, bc;
        logic [7:0] pdat;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", v8, 0);
        check_eq("rst_data", d8_o, 0);
        check_eq("rst_ferr", fe8_o, 0);
        check_eq("rst_perr", pe8_o, 0);
        check_eq("rst_ovr", ovr8_o, 0);
        check_eq("rst_state", int'(dut8.r_state), int'(ST_IDLE));
        @(posedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // 8N1 0xA5 at divisor 27
        bc = bit_cycles(div);
        b = frm8;
        send_frame(0, 8'hA5, 8, 0, 0, 1, 1, 1, bc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("a5_count", frm8 - b, 1);
        check_eq("a5_data", cap_d8, 8'hA5);
        check_eq("a5_ferr", cap_fe8, 0);
        check_eq("a5_perr", cap_pe8, 0);
        check_eq("a5_valid_pulse", v8, 0);

        // 7E1 0x55 with parity bit inverted
        div = 16'd5; par_en = 1'b1; par_odd = 1'b0;
        bc = bit_cycles(div);
        b = frm7;
        send_frame(1, 8'h55, 7, 1, ~(^(8'h55 & 8'h7F)), 1, 1, 1, bc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("7e1_count", frm7 - b, 1);
        check_eq("7e1_data", cap_d7, 8'h55);
        check_eq("7e1_perr", cap_pe7, 1);
        check_eq("7e1_ferr", cap_fe7, 0);

        // 8O1 0x07 with correct odd parity
        par_odd = 1'b1;
        pdat = 8'h07;
        b = frm8;
        send_frame(0, pdat, 8, 1, (^pdat) ^ 1'b1, 1, 1, 1, bc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("8o1_data", cap_d8, 8'h07);
        check_eq("8o1_perr", cap_pe8, 0);
        check_eq("8o1_count", frm8 - b, 1);

        // 8N2 0x3C with second stop bit low
        par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b1;
        b = frm8;
        send_frame(0, 8'h3C, 8, 0, 0, 1, 0, 2, bc);
        repeat (2 * bc) @(posedge clk);
        @(negedge clk);
        check_eq("8n2_count", frm8 - b, 1);
        check_eq("8n2_data", cap_d8, 8'h3C);
        check_eq("8n2_ferr", cap_fe8, 1);
        check_eq("8n2_perr", cap_pe8, 0);
        check_eq("8n2_idle", int'(dut8.r_state), int'(ST_IDLE));
        stop2 = 1'b0;

        // Low glitch of four oversample ticks
        b = frm8;
        drive(0, 1'b0, 4 * int'(div));
        drive(0, 1'b1, 2 * bc);
        @(negedge clk);
        check_eq("glitch_count", frm8 - b, 0);
        check_eq("glitch_idle", int'(dut8.r_state), int'(ST_IDLE));

        // Back-to-back 0x11, 0x22 with consumer stalled
        @(posedge clk);
        ready = 1'b0;
        b = frm8; bo = ov8;
        send_frame(0, 8'h11, 8, 0, 0, 1, 1, 1, bc);
        send_frame(0, 8'h22, 8, 0, 0, 1, 1, 1, bc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("ovr_valid", v8, 1);
        check_eq("ovr_data", d8_o, 8'h11);
        check_eq("ovr_pulses", ov8 - bo, 1);
        check_eq("ovr_count", frm8 - b, 1);
        @(posedge clk);
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("ovr_drain", v8, 0);

        // Reset during data bit 3, then 0x7E
        b = frm8; bo = ov8;
        drive(0, 1'b0, bc);
        for (int i = 0; i < 3; i++) drive(0, i[0], bc);
        drive(0, 1'b1, bc / 2);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 2 * bc);
        send_frame(0, 8'h7E, 8, 0, 0, 1, 1, 1, bc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("rstmid_count", frm8 - b, 1);
        check_eq("rstmid_data", cap_d8, 8'h7E);
        check_eq("rstmid_ovr", ov8 - bo, 0);

        // Divisor 0 behaves as 1
        div = 16'd0;
        bc = bit_cycles(div);
        drive(0, 1'b1, 4 * bc);
        b = frm8;
        send_frame(0, 8'h81, 8, 0, 0, 1, 1, 1, bc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("div0_count", frm8 - b, 1);
        check_eq("div0_data", cap_d8, 8'h81);
        check_eq("div0_ferr", cap_fe8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
